mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the number of BUSY cycles without bus_ack before abort (range 1..1023).
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF, sets the read data returned on a timed-out read.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 if_req  in  1  instruction fetch request (from IF inst_ren).
REQ-006 if_addr  in  32  instruction address.
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_ready  out  1  one-cycle pulse; if_rdata valid.
REQ-009 d_ren / d_wen  in  1 each  data read / write request (from MEM stage).
REQ-010 d_addr, d_wdata  in  32 each  data address, write data.
REQ-011 d_rdata  out  32  load data.
REQ-012 d_ready  out  1  one-cycle pulse; data access complete.
REQ-013 if_stall, mem_stall  out  1 each  stall indications to pipeline control.
REQ-014 bus_cyc, bus_we  out  1 each  unified memory bus cycle, write strobe.
REQ-015 bus_addr, bus_wdata  out  32 each  bus address, write data.
REQ-016 bus_rdata  in  32  bus read data; bus_ack  in  1  bus completion.
REQ-017 err_clr  in  1  clears err_sticky; bus_err  out  1  timeout pulse; err_sticky  out  1  latched timeout.

Function
REQ-018 FSM states SHALL be IDLE, IBUSY, DBUSY, DONE.
REQ-019 IDLE: if d_ren|d_wen, latch d_addr/d_wdata/d_wen, go DBUSY; else if if_req, latch if_addr, go IBUSY; else stay.
REQ-020 Data requests SHALL have fixed priority over instruction requests when both are present in IDLE.
REQ-021 d_ren and d_wen both high SHALL be treated as a write.
REQ-022 In IBUSY/DBUSY, bus_cyc=1 and bus_addr/bus_we/bus_wdata SHALL hold latched values, stable until exit.
REQ-023 bus_we=1 only in DBUSY for a write; bus_wdata=0 for reads.
REQ-024 On bus_ack in BUSY: capture bus_rdata into the owner's rdata register, go DONE.
REQ-025 DONE lasts exactly one cycle: owner's ready=1, bus_cyc=0, requests ignored; then IDLE.
REQ-026 Minimum latency: request sampled at edge N, bus_cyc high in cycle N+1, ack in N+1 gives ready in cycle N+2; back-to-back transactions are therefore 3 cycles apart.
REQ-027 bus_ack outside IBUSY/DBUSY SHALL be ignored.
REQ-028 if_rdata/d_rdata SHALL hold their last captured value until the next completion of the same owner.
REQ-029 The timeout counter SHALL clear on BUSY entry and increment per BUSY cycle without ack; at TIMEOUT_CYCLES it goes DONE with ready=1, bus_err pulsed 1 cycle, err_sticky=1, and rdata=ERR_RDATA for reads.
REQ-030 An ack in the same cycle the count reaches TIMEOUT_CYCLES SHALL win, with no error.
REQ-031 err_sticky SHALL clear on err_clr unless a timeout fires the same cycle; the timeout wins.
REQ-032 if_stall = if_req & ~if_ready; mem_stall = (d_ren|d_wen) & ~d_ready; both combinational.
REQ-033 A request withdrawn while its transaction is in BUSY SHALL still complete on the bus; the ready pulse is still issued.

Reset
REQ-034 rst_n low SHALL force IDLE immediately, without waiting for clk, and drive bus_cyc=0 in the same instant.
REQ-035 Reset values: all outputs 0, rdata registers 0, counter 0, err_sticky 0.
REQ-036 Reset mid-transaction SHALL abort it silently: no ready pulse, no bus_err.

Structure
REQ-037 State encoding constants and the TIMEOUT_CYCLES default SHALL live in the shared define header.
REQ-038 The timeout counter SHALL be one sub-module, bus_timer (clear, enable, expired output).

Verification
REQ-039 Single ifetch: if_req=1, if_addr=0x0000_0040, ack after 2 BUSY cycles with rdata 0x2008_0005 -> if_ready pulse, if_rdata=0x2008_0005, bus_we=0 throughout.
REQ-040 Simultaneous: if_req and d_ren in the same IDLE cycle -> DBUSY first with bus_addr=d_addr; IBUSY follows after DONE+IDLE.
REQ-041 Write: d_wen=1, d_addr=0x10, d_wdata=0xDEAD_BEEF -> bus_we=1, bus_wdata=0xDEAD_BEEF held until ack; d_ready one pulse.
REQ-042 Timeout: TIMEOUT_CYCLES=4, d_ren with no ack -> d_ready and bus_err in the same cycle after 4 BUSY cycles, d_rdata=0xFFFF_FFFF, err_sticky=1 until err_clr.
REQ-043 Reset mid-DBUSY: rst_n low -> bus_cyc=0 before the next edge, no d_ready pulse; normal operation after release.
REQ-044 Stray ack in IDLE and in DONE -> no state change, no ready pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, timer sizing
// and the parameter defaults used by the top level and the bus timer.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int          TIMER_WIDTH            = 10;
    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arbiter_bus_timer.sv
// Bus timeout counter: counts BUSY cycles without an acknowledge and flags
// the cycle in which the LIMIT-th such cycle is reached.
module bus_timer
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES,
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Count un-acknowledged BUSY cycles; cleared whenever the bus is not owned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one memory bus between instruction fetch and the
// data stage, data having fixed priority, with a per-transaction timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        if_stall,
    output logic        mem_stall,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        err_clr,
    output logic        bus_err,
    output logic        err_sticky
);

    arb_state_t  state_q;
    arb_state_t  state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        owner_data_q;
    logic        timeout_hit_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        err_sticky_q;

    logic busy;
    logic d_any;
    logic take_data;
    logic take_inst;
    logic timer_expired;

    assign busy      = (state_q == ST_IBUSY) || (state_q == ST_DBUSY);
    assign d_any     = d_ren | d_wen;
    assign take_data = (state_q == ST_IDLE) && d_any;
    assign take_inst = (state_q == ST_IDLE) && !d_any && if_req;

    bus_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TIMER_WIDTH)
    ) u_bus_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!busy),
        .enable  (busy && !bus_ack),
        .expired (timer_expired)
    );

    // State register; reset drops straight to IDLE so the bus releases at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic: data beats instruction, DONE always lasts one cycle
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (d_any) begin
                    state_next = ST_DBUSY;
                end else if (if_req) begin
                    state_next = ST_IBUSY;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                if (bus_ack || timer_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request so the bus sees stable values for the whole transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_data_q <= 1'b0;
        end else if (take_data) begin
            addr_q       <= d_addr;
            wdata_q      <= d_wen ? d_wdata : 32'h0;
            we_q         <= d_wen;
            owner_data_q <= 1'b1;
        end else if (take_inst) begin
            addr_q       <= if_addr;
            wdata_q      <= 32'h0;
            we_q         <= 1'b0;
            owner_data_q <= 1'b0;
        end
    end

    // Capture read data for the owner; a timed-out read returns the error pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (busy && bus_ack) begin
            if (owner_data_q) begin
                d_rdata_q <= bus_rdata;
            end else begin
                if_rdata_q <= bus_rdata;
            end
        end else if (busy && timer_expired && !we_q) begin
            if (owner_data_q) begin
                d_rdata_q <= ERR_RDATA;
            end else begin
                if_rdata_q <= ERR_RDATA;
            end
        end
    end

    // Remember a timeout for the DONE pulse and in the sticky flag; timeout beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_hit_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            timeout_hit_q <= busy && timer_expired;
            if (busy && timer_expired) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bus_cyc    = busy;
    assign bus_addr   = busy ? addr_q : 32'h0;
    assign bus_we     = (state_q == ST_DBUSY) && we_q;
    assign bus_wdata  = bus_we ? wdata_q : 32'h0;
    assign if_ready   = (state_q == ST_DONE) && !owner_data_q;
    assign d_ready    = (state_q == ST_DONE) && owner_data_q;
    assign bus_err    = (state_q == ST_DONE) && timeout_hit_q;
    assign err_sticky = err_sticky_q;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign if_stall   = if_req & ~if_ready;
    assign mem_stall  = d_any & ~d_ready;

endmodule
